mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Data-memory access stage between the EX/MEM and MEM/WB pipeline registers. Takes the memory control, address (ALU result) and store data latched in EX/MEM and performs byte/half/word loads and stores over a req/ack data-memory port. It stalls the pipeline until the access completes and presents the aligned, extended load result as `MEM_Data_memory_Read_data` to MEM/WB. Covers multi-cycle memories, misaligned-access detection and a bus-timeout watchdog.

## Interface
Parameters:
- `word`, 32, datapath width
- `TIMEOUT`, 255, maximum WAIT cycles before bus error (1..255, 8-bit counter)

Ports (one clock; reset is asynchronous and active-low):
- `Clock`  in  1  pipeline clock, rising edge
- `Reset_n`  in  1  asynchronous active-low reset
- `MEM_MemRead`  in  1  load in MEM stage
- `MEM_MemWrite`  in  1  store in MEM stage
- `MEM_MemSize`  in  2  00 byte, 01 half, 10 word, 11 treated as word
- `MEM_MemSigned`  in  1  1 = sign-extend load, 0 = zero-extend
- `MEM_ALU_result`  in  word  byte address
- `MEM_Write_data`  in  word  store data (rt)
- `MEM_Data_memory_Read_data`  out  word  aligned/extended load result to MEM/WB
- `Stall_MEM`  out  1  freeze PC, IF/ID, ID/EX and EX/MEM; bubble into MEM/WB
- `Misaligned`  out  1  access suppressed due to alignment (one cycle per instruction)
- `Bus_error`  out  1  timeout pulse (one cycle, in DONE)
- `Dmem_req`  out  1  request, held until ack
- `Dmem_we`  out  1  1 = write
- `Dmem_addr`  out  word  word-aligned address (`[1:0]`=0)
- `Dmem_wdata`  out  word  lane-replicated store data
- `Dmem_be`  out  4  byte enables, bit0 = byte at addr[1:0]=0 (little-endian)
- `Dmem_rdata`  in  word  read word, valid with ack
- `Dmem_ack`  in  1  completion, sampled only in WAIT

## Operation
- FSM: IDLE, WAIT, DONE.
- IDLE: access = `MEM_MemRead|MEM_MemWrite`.
  - If access and aligned: register `Dmem_req`=1, `Dmem_we`=`MEM_MemWrite`, `Dmem_addr`, `Dmem_wdata`, `Dmem_be`; clear the watchdog; go to WAIT.
  - If access and misaligned (half with addr[0]=1, word with addr[1:0]≠0): `Misaligned`=1 combinationally, no request, no stall, read data 0, stay IDLE.
- Both read and write high: store performed, read data 0.
- WAIT: on `Dmem_ack`, drop req/we/be, capture the load result, go to DONE. Otherwise increment the watchdog. When the count reaches `TIMEOUT`, drop req, set read data 0, raise `Bus_error`, go to DONE.
- DONE: no stall; the pipeline advances at this edge; clear `Bus_error`; go to IDLE unconditionally, so the same instruction is never re-issued.
- Store lanes: byte: wdata = {4{wd[7:0]}}, be = 0001<<addr[1:0]. Half: {2{wd[15:0]}}, be = 0011<<addr[1:0]. Word: be = 1111.
- Load extract: byte = rdata[8*addr[1:0] +: 8], half = rdata[16*addr[1] +: 16], extended per `MEM_MemSigned`. Addr/size/signed come from held EX/MEM values, which are stable while stalled.
- `MEM_Data_memory_Read_data` is registered. It holds its value until the next completed load; a store leaves it unchanged.
- `Stall_MEM` = `Reset_n` & ((IDLE & access & aligned) | WAIT).

## Timing
- Reset (async assert): state IDLE; `Dmem_req`, `Dmem_we`, `Dmem_addr`, `Dmem_wdata`, `Dmem_be`, `MEM_Data_memory_Read_data`, `Bus_error`, watchdog all 0; `Stall_MEM` 0. A reset mid-WAIT drops req immediately; the outstanding ack is ignored.
- Minimum access is 3 cycles with 2 stalled:
  - C0: IDLE, stall.
  - C1: WAIT, req high, ack high.
  - C2: DONE, data valid, no stall.
- Each ack-wait cycle adds one stall cycle.
- Timeout: `Bus_error` high in the DONE cycle that follows `TIMEOUT` WAIT cycles without ack.
- Ack in IDLE or DONE is ignored. Req deasserts on the edge after ack; memory must not ack twice.
- Back-to-back accesses: the second access's IDLE cycle directly follows DONE. There is no extra bubble beyond the 2 stall cycles.

## Structure
- Shared package `mem_pkg`:
  - size encodings `MEM_BYTE`/`MEM_HALF`/`MEM_WORD`
  - FSM state enum
  - `TIMEOUT` default
- One combinational sub-module, `mem_lane_align`: store replication, byte-enable generation, misalignment check, load extract/extend. Used by the FSM top.

## Test plan
- `lw` addr 0x100, memory acks on the first req cycle, rdata 0xDEADBEEF -> `Stall_MEM` high exactly 2 cycles, DONE read data 0xDEADBEEF, `Dmem_addr` 0x100, be 1111.
- `lb` signed addr 0x103, rdata 0x80FF_FF7F, then `lbu` same addr -> 0xFFFFFF80, then 0x00000080.
- `sh` addr 0x102, wd 0x1234ABCD, ack after 4 wait cycles -> wdata 0xABCDABCD, be 1100, we 1, stall 5 cycles, read data unchanged.
- `lw` addr 0x101 -> `Misaligned` 1 for one cycle, `Dmem_req` never rises, no stall, read data 0.
- Load with no ack, `TIMEOUT`=4 -> req drops after 4 WAIT cycles, `Bus_error` pulses 1 cycle, read data 0, pipeline resumes.
- Reset_n low during WAIT -> req/be/stall 0 immediately; a later ack is ignored; FSM in IDLE.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage data-memory access unit.
package mem_pkg;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  localparam int TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } mem_state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for a little-endian 32-bit data memory: store replication,
// byte enables, alignment check and load extraction with sign/zero extension.
module mem_lane_align
  import mem_pkg::*;
#(
  parameter int word = 32
) (
  input  logic [1:0]      mem_size,
  input  logic            mem_signed,
  input  logic [1:0]      byte_off,
  input  logic [word-1:0] store_data,
  input  logic [word-1:0] read_word,
  output logic [word-1:0] lane_wdata,
  output logic [3:0]      lane_be,
  output logic            misaligned,
  output logic [word-1:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Size 11 falls into the default arm and behaves as a word access.
  always_comb begin
    byte_sel   = read_word[8*byte_off +: 8];
    half_sel   = read_word[16*byte_off[1] +: 16];
    lane_wdata = store_data;
    lane_be    = 4'b1111;
    misaligned = 1'b0;
    load_data  = read_word;
    case (mem_size)
      MEM_BYTE: begin
        lane_wdata = {4{store_data[7:0]}};
        lane_be    = 4'b0001 << byte_off;
        load_data  = mem_signed ? {{(word-8){byte_sel[7]}}, byte_sel}
                                : {{(word-8){1'b0}}, byte_sel};
      end
      MEM_HALF: begin
        lane_wdata = {2{store_data[15:0]}};
        lane_be    = 4'b0011 << byte_off;
        misaligned = byte_off[0];
        load_data  = mem_signed ? {{(word-16){half_sel[15]}}, half_sel}
                                : {{(word-16){1'b0}}, half_sel};
      end
      default: begin
        misaligned = (byte_off != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access FSM: issues one req/ack transaction per load or
// store, stalls the pipeline until it completes, and guards the bus with a watchdog.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int word    = 32,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic            Clock,
  input  logic            Reset_n,
  input  logic            MEM_MemRead,
  input  logic            MEM_MemWrite,
  input  logic [1:0]      MEM_MemSize,
  input  logic            MEM_MemSigned,
  input  logic [word-1:0] MEM_ALU_result,
  input  logic [word-1:0] MEM_Write_data,
  output logic [word-1:0] MEM_Data_memory_Read_data,
  output logic            Stall_MEM,
  output logic            Misaligned,
  output logic            Bus_error,
  output logic            Dmem_req,
  output logic            Dmem_we,
  output logic [word-1:0] Dmem_addr,
  output logic [word-1:0] Dmem_wdata,
  output logic [3:0]      Dmem_be,
  input  logic [word-1:0] Dmem_rdata,
  input  logic            Dmem_ack
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  mem_state_e      state;
  logic [7:0]      watchdog;
  logic            access;
  logic            misaligned_acc;
  logic [word-1:0] lane_wdata;
  logic [3:0]      lane_be;
  logic [word-1:0] load_data;

  assign access = MEM_MemRead | MEM_MemWrite;

  mem_lane_align #(.word(word)) u_lane_align (
    .mem_size   (MEM_MemSize),
    .mem_signed (MEM_MemSigned),
    .byte_off   (MEM_ALU_result[1:0]),
    .store_data (MEM_Write_data),
    .read_word  (Dmem_rdata),
    .lane_wdata (lane_wdata),
    .lane_be    (lane_be),
    .misaligned (misaligned_acc),
    .load_data  (load_data)
  );

  assign Misaligned = Reset_n && (state == ST_IDLE) && access && misaligned_acc;
  assign Stall_MEM  = Reset_n && (((state == ST_IDLE) && access && !misaligned_acc)
                                  || (state == ST_WAIT));

  // DONE always returns to IDLE so a completed instruction is never re-issued.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state                     <= ST_IDLE;
      watchdog                  <= 8'd0;
      Dmem_req                  <= 1'b0;
      Dmem_we                   <= 1'b0;
      Dmem_addr                 <= '0;
      Dmem_wdata                <= '0;
      Dmem_be                   <= 4'b0000;
      MEM_Data_memory_Read_data <= '0;
      Bus_error                 <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (access && !misaligned_acc) begin
            Dmem_req   <= 1'b1;
            Dmem_we    <= MEM_MemWrite;
            Dmem_addr  <= {MEM_ALU_result[word-1:2], 2'b00};
            Dmem_wdata <= lane_wdata;
            Dmem_be    <= lane_be;
            watchdog   <= 8'd0;
            state      <= ST_WAIT;
          end else if (access) begin
            MEM_Data_memory_Read_data <= '0;
          end
        end
        ST_WAIT: begin
          if (Dmem_ack) begin
            Dmem_req <= 1'b0;
            Dmem_we  <= 1'b0;
            Dmem_be  <= 4'b0000;
            if (MEM_MemRead && MEM_MemWrite) begin
              MEM_Data_memory_Read_data <= '0;
            end else if (MEM_MemRead) begin
              MEM_Data_memory_Read_data <= load_data;
            end
            state <= ST_DONE;
          end else begin
            watchdog <= watchdog + 8'd1;
            if (watchdog + 8'd1 == TIMEOUT_CNT) begin
              Dmem_req                  <= 1'b0;
              Dmem_we                   <= 1'b0;
              Dmem_be                   <= 4'b0000;
              MEM_Data_memory_Read_data <= '0;
              Bus_error                 <= 1'b1;
              state                     <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          Bus_error <= 1'b0;
          state     <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: a scoreboard of expected load results
// and stall/wait counts is filled at issue and drained when each access completes.
module tb_mem_access_unit;

  localparam int TB_TIMEOUT = 4;

  logic        Clock;
  logic        Reset_n;
  logic        MEM_MemRead;
  logic        MEM_MemWrite;
  logic [1:0]  MEM_MemSize;
  logic        MEM_MemSigned;
  logic [31:0] MEM_ALU_result;
  logic [31:0] MEM_Write_data;
  logic [31:0] MEM_Data_memory_Read_data;
  logic        Stall_MEM;
  logic        Misaligned;
  logic        Bus_error;
  logic        Dmem_req;
  logic        Dmem_we;
  logic [31:0] Dmem_addr;
  logic [31:0] Dmem_wdata;
  logic [3:0]  Dmem_be;
  logic [31:0] Dmem_rdata;
  logic        Dmem_ack;

  typedef struct {
    string       name;
    logic [31:0] rd;
    logic        berr;
    int          stalls;
    int          waits;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  mem_access_unit #(.word(32), .TIMEOUT(TB_TIMEOUT)) dut (
    .Clock                     (Clock),
    .Reset_n                   (Reset_n),
    .MEM_MemRead               (MEM_MemRead),
    .MEM_MemWrite              (MEM_MemWrite),
    .MEM_MemSize               (MEM_MemSize),
    .MEM_MemSigned             (MEM_MemSigned),
    .MEM_ALU_result            (MEM_ALU_result),
    .MEM_Write_data            (MEM_Write_data),
    .MEM_Data_memory_Read_data (MEM_Data_memory_Read_data),
    .Stall_MEM                 (Stall_MEM),
    .Misaligned                (Misaligned),
    .Bus_error                 (Bus_error),
    .Dmem_req                  (Dmem_req),
    .Dmem_we                   (Dmem_we),
    .Dmem_addr                 (Dmem_addr),
    .Dmem_wdata                (Dmem_wdata),
    .Dmem_be                   (Dmem_be),
    .Dmem_rdata                (Dmem_rdata),
    .Dmem_ack                  (Dmem_ack)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Issues one aligned access and plays the memory: ack in WAIT cycle ack_lat (0 = never).
  task automatic applyStimulus(input string name, input logic rd, input logic wr,
                               input logic [1:0] size, input logic sgn,
                               input logic [31:0] addr, input logic [31:0] wd,
                               input logic [31:0] rdata, input int ack_lat,
                               input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                               input logic [3:0] exp_be, input logic [31:0] exp_rd);
    exp_t e;
    exp_t got_e;
    int   stalls = 0;
    int   waits  = 0;
    bit   done   = 0;
    e.name   = name;
    e.rd     = exp_rd;
    e.berr   = (ack_lat == 0);
    e.stalls = (ack_lat == 0) ? TB_TIMEOUT + 1 : ack_lat + 1;
    e.waits  = (ack_lat == 0) ? TB_TIMEOUT : ack_lat;
    sb_q.push_back(e);
    MEM_MemRead    = rd;
    MEM_MemWrite   = wr;
    MEM_MemSize    = size;
    MEM_MemSigned  = sgn;
    MEM_ALU_result = addr;
    MEM_Write_data = wd;
    Dmem_ack       = 1'b0;
    Dmem_rdata     = 32'h5A5A_5A5A;
    #1;
    for (int c = 0; c < 600 && !done; c++) begin
      if (Stall_MEM) stalls++;
      if (Dmem_req) begin
        waits++;
        if (waits == 1) begin
          checkOutput({name, ".addr"}, Dmem_addr, exp_addr);
          checkOutput({name, ".wdata"}, Dmem_wdata, exp_wdata);
          checkOutput({name, ".be"}, 32'(Dmem_be), 32'(exp_be));
          checkOutput({name, ".we"}, 32'(Dmem_we), 32'(wr));
        end
        if (ack_lat != 0 && waits == ack_lat) begin
          Dmem_ack   = 1'b1;
          Dmem_rdata = rdata;
        end else begin
          Dmem_ack   = 1'b0;
          Dmem_rdata = 32'h5A5A_5A5A;
        end
      end else begin
        Dmem_ack = 1'b0;
        if (waits > 0) begin
          done = 1;
          if (sb_q.size() == 0) begin
            checkOutput({name, ".sb_nonempty"}, 32'(sb_q.size()), 32'd1);
          end else begin
            got_e = sb_q.pop_front();
            checkOutput({got_e.name, ".rdata"}, MEM_Data_memory_Read_data, got_e.rd);
            checkOutput({got_e.name, ".bus_error"}, 32'(Bus_error), 32'(got_e.berr));
            checkOutput({got_e.name, ".stall_cycles"}, 32'(stalls), 32'(got_e.stalls));
            checkOutput({got_e.name, ".wait_cycles"}, 32'(waits), 32'(got_e.waits));
            checkOutput({got_e.name, ".done_we"}, 32'(Dmem_we), 32'd0);
          end
        end
      end
      if (!done) begin
        @(posedge Clock);
        @(negedge Clock);
        #1;
      end
    end
    checkOutput({name, ".completed"}, 32'(done), 32'd1);
    @(posedge Clock);
    @(negedge Clock);
    MEM_MemRead  = 1'b0;
    MEM_MemWrite = 1'b0;
    #1;
    checkOutput({name, ".bus_error_clear"}, 32'(Bus_error), 32'd0);
  endtask

  // Misaligned access: flagged for its single cycle, never requested, read data zeroed.
  task automatic applyMisaligned(input string name, input logic rd, input logic wr,
                                 input logic [1:0] size, input logic [31:0] addr);
    exp_t e;
    exp_t got_e;
    e.name = name; e.rd = 32'h0; e.berr = 1'b0; e.stalls = 0; e.waits = 0;
    sb_q.push_back(e);
    MEM_MemRead    = rd;
    MEM_MemWrite   = wr;
    MEM_MemSize    = size;
    MEM_MemSigned  = 1'b0;
    MEM_ALU_result = addr;
    MEM_Write_data = 32'hFFFF_FFFF;
    #1;
    checkOutput({name, ".misaligned"}, 32'(Misaligned), 32'd1);
    checkOutput({name, ".stall"}, 32'(Stall_MEM), 32'd0);
    checkOutput({name, ".req"}, 32'(Dmem_req), 32'd0);
    @(posedge Clock);
    @(negedge Clock);
    got_e = sb_q.pop_front();
    checkOutput({got_e.name, ".rdata"}, MEM_Data_memory_Read_data, got_e.rd);
    checkOutput({got_e.name, ".req_after"}, 32'(Dmem_req), 32'd0);
    MEM_MemRead  = 1'b0;
    MEM_MemWrite = 1'b0;
    #1;
    checkOutput({name, ".misaligned_clear"}, 32'(Misaligned), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout got=running exp=finished");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    Reset_n        = 1'b1;
    MEM_MemRead    = 1'b0;
    MEM_MemWrite   = 1'b0;
    MEM_MemSize    = 2'b00;
    MEM_MemSigned  = 1'b0;
    MEM_ALU_result = 32'h0;
    MEM_Write_data = 32'h0;
    Dmem_rdata     = 32'h0;
    Dmem_ack       = 1'b0;
    #1 Reset_n = 1'b0;
    @(negedge Clock);
    @(negedge Clock);
    checkOutput("reset.req", 32'(Dmem_req), 32'd0);
    checkOutput("reset.we", 32'(Dmem_we), 32'd0);
    checkOutput("reset.addr", Dmem_addr, 32'h0);
    checkOutput("reset.wdata", Dmem_wdata, 32'h0);
    checkOutput("reset.be", 32'(Dmem_be), 32'd0);
    checkOutput("reset.rdata", MEM_Data_memory_Read_data, 32'h0);
    checkOutput("reset.bus_error", 32'(Bus_error), 32'd0);
    checkOutput("reset.stall", 32'(Stall_MEM), 32'd0);
    Reset_n = 1'b1;
    @(negedge Clock);

    // Back-to-back accesses: each task returns at the IDLE cycle of the next.
    applyStimulus("lw_100",   1, 0, 2'b10, 0, 32'h100, 32'h1111_2222, 32'hDEAD_BEEF, 1,
                  32'h100, 32'h1111_2222, 4'b1111, 32'hDEAD_BEEF);
    applyStimulus("lb_103",   1, 0, 2'b00, 1, 32'h103, 32'h0, 32'h80FF_FF7F, 1,
                  32'h100, 32'h0, 4'b1000, 32'hFFFF_FF80);
    applyStimulus("lbu_103",  1, 0, 2'b00, 0, 32'h103, 32'h0, 32'h80FF_FF7F, 1,
                  32'h100, 32'h0, 4'b1000, 32'h0000_0080);
    applyStimulus("sh_102",   0, 1, 2'b01, 0, 32'h102, 32'h1234_ABCD, 32'h0, 4,
                  32'h100, 32'hABCD_ABCD, 4'b1100, 32'h0000_0080);
    applyStimulus("lh_102",   1, 0, 2'b01, 1, 32'h102, 32'h0, 32'h8001_7FFF, 2,
                  32'h100, 32'h0, 4'b1100, 32'hFFFF_8001);
    applyStimulus("lhu_100",  1, 0, 2'b01, 0, 32'h100, 32'h0, 32'h1234_F00D, 1,
                  32'h100, 32'h0, 4'b0011, 32'h0000_F00D);
    applyStimulus("sb_201",   0, 1, 2'b00, 0, 32'h201, 32'h0000_00A5, 32'h0, 3,
                  32'h200, 32'hA5A5_A5A5, 4'b0010, 32'h0000_F00D);
    applyStimulus("rdwr_300", 1, 1, 2'b11, 0, 32'h300, 32'hCAFE_F00D, 32'h7777_7777, 1,
                  32'h300, 32'hCAFE_F00D, 4'b1111, 32'h0);
    applyStimulus("lw_104",   1, 0, 2'b10, 0, 32'h104, 32'h0, 32'h0BAD_F00D, 1,
                  32'h104, 32'h0, 4'b1111, 32'h0BAD_F00D);
    applyStimulus("lw_to",    1, 0, 2'b10, 0, 32'h400, 32'h0, 32'h0, 0,
                  32'h400, 32'h0, 4'b1111, 32'h0);
    applyStimulus("lw_108",   1, 0, 2'b10, 0, 32'h108, 32'h0, 32'h55AA_55AA, 1,
                  32'h108, 32'h0, 4'b1111, 32'h55AA_55AA);
    applyMisaligned("lw_101", 1, 0, 2'b10, 32'h101);

    // Reset in WAIT: req drops at once and a late ack must not restart anything.
    MEM_MemRead    = 1'b1;
    MEM_MemSize    = 2'b10;
    MEM_ALU_result = 32'h500;
    @(posedge Clock);
    @(negedge Clock);
    checkOutput("rst_wait.req_before", 32'(Dmem_req), 32'd1);
    Reset_n = 1'b0;
    #1;
    checkOutput("rst_wait.req", 32'(Dmem_req), 32'd0);
    checkOutput("rst_wait.be", 32'(Dmem_be), 32'd0);
    checkOutput("rst_wait.stall", 32'(Stall_MEM), 32'd0);
    @(negedge Clock);
    Reset_n     = 1'b1;
    MEM_MemRead = 1'b0;
    Dmem_ack    = 1'b1;
    Dmem_rdata  = 32'hFFFF_FFFF;
    @(posedge Clock);
    @(negedge Clock);
    Dmem_ack = 1'b0;
    #1;
    checkOutput("rst_wait.late_ack_req", 32'(Dmem_req), 32'd0);
    checkOutput("rst_wait.late_ack_stall", 32'(Stall_MEM), 32'd0);
    checkOutput("rst_wait.late_ack_rdata", MEM_Data_memory_Read_data, 32'h0);
    checkOutput("rst_wait.late_ack_berr", 32'(Bus_error), 32'd0);
    @(negedge Clock);
    applyStimulus("lw_600",   1, 0, 2'b10, 0, 32'h600, 32'h0, 32'h1357_9BDF, 1,
                  32'h600, 32'h0, 4'b1111, 32'h1357_9BDF);

    checkOutput("scoreboard.drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
